// File: rtl/pid_pkg.sv
`timescale 1ns/1ps
// Shared types, default parameters and the burst classifier for pulse_interval_decode.
package pid_pkg;

  localparam int unsigned PID_CNT_W      = 5;
  localparam int unsigned PID_GAP_CYCLES = 4;
  localparam int unsigned PID_MIN_PULSES = 3;
  localparam int unsigned PID_ONE_MIN    = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } pid_state_e;

  typedef enum logic [1:0] {
    CLS_DROP,
    CLS_ZERO,
    CLS_ONE
  } pid_cls_e;

  function automatic pid_cls_e pid_classify(input int unsigned cnt,
                                            input int unsigned min_pulses,
                                            input int unsigned one_min);
    if (cnt < min_pulses) return CLS_DROP;
    if (cnt < one_min)    return CLS_ZERO;
    return CLS_ONE;
  endfunction

endpackage

// File: rtl/pid_edge_sync.sv
`timescale 1ns/1ps
// Two-flop synchroniser for the asynchronous ZCD pulse plus a one-cycle rising-edge detector.
module pid_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic sync_qq, sync_qq_d;

  always_comb begin
    meta_d    = async_in;
    sync_d    = meta_q;
    sync_qq_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so each stage captures its predecessor's pre-edge value; blocking would collapse the chain.
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      sync_qq <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      sync_qq <= sync_qq_d;
    end
  end

  assign rise = sync_q & ~sync_qq;

endmodule

// File: rtl/pulse_interval_decode.sv
`timescale 1ns/1ps
// Pulse-interval burst decoder: counts carrier pulses per burst and strobes a 0/1 symbol after a silent gap.
// Optional PID_ERR_FLAG_EN adds err_flag for rejected (too short) or saturated bursts.
module pulse_interval_decode
  import pid_pkg::*;
#(
  parameter int unsigned CNT_W      = PID_CNT_W,
  parameter int unsigned GAP_CYCLES = PID_GAP_CYCLES,
  parameter int unsigned MIN_PULSES = PID_MIN_PULSES,
  parameter int unsigned ONE_MIN    = PID_ONE_MIN
) (
  input  logic             sclk_3mhz,
  input  logic             reset_n,
  input  logic             zcd_pulse,
  output logic [CNT_W-1:0] zero_clock_count,
  output logic [CNT_W-1:0] one_clock_count,
  output logic             zero_flag,
  output logic             one_flag
`ifdef PID_ERR_FLAG_EN
  ,
  output logic             err_flag
`endif
);

  localparam int unsigned      GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic rise;

  pid_edge_sync u_edge_sync (
    .clk     (sclk_3mhz),
    .rst_n   (reset_n),
    .async_in(zcd_pulse),
    .rise    (rise)
  );

  pid_state_e       state_q, state_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
  logic [CNT_W-1:0] one_cnt_q, one_cnt_d;
  logic             zero_flag_q, zero_flag_d;
  logic             one_flag_q, one_flag_d;
  logic             burst_start, burst_done;
  pid_cls_e         cls;

  always_comb begin
    // NOTE: every signal gets a default first so no branch leaves it unassigned and infers a latch.
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    zero_cnt_d  = zero_cnt_q;
    one_cnt_d   = one_cnt_q;
    zero_flag_d = 1'b0;
    one_flag_d  = 1'b0;
    burst_start = (state_q == IDLE) && rise;
    // A rise on the expiry cycle extends the burst instead of ending it.
    burst_done  = (state_q == BURST) && !rise && (gap_cnt_q == GAP_LAST);
    cls         = pid_classify(32'(pulse_cnt_q), MIN_PULSES, ONE_MIN);

    if (burst_start) begin
      state_d     = BURST;
      pulse_cnt_d = CNT_W'(1);
      gap_cnt_d   = '0;
    end else if (state_q == BURST) begin
      if (rise) begin
        gap_cnt_d = '0;
        if (pulse_cnt_q != CNT_MAX) pulse_cnt_d = pulse_cnt_q + 1'b1;
      end else if (burst_done) begin
        state_d = IDLE;
        case (cls)
          CLS_ZERO: begin
            zero_flag_d = 1'b1;
            zero_cnt_d  = pulse_cnt_q;
          end
          CLS_ONE: begin
            one_flag_d = 1'b1;
            one_cnt_d  = pulse_cnt_q;
          end
          default: ;
        endcase
      end else begin
        gap_cnt_d = gap_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sclk_3mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      gap_cnt_q   <= '0;
      zero_cnt_q  <= '0;
      one_cnt_q   <= '0;
      zero_flag_q <= 1'b0;
      one_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      zero_cnt_q  <= zero_cnt_d;
      one_cnt_q   <= one_cnt_d;
      zero_flag_q <= zero_flag_d;
      one_flag_q  <= one_flag_d;
    end
  end

  assign zero_clock_count = zero_cnt_q;
  assign one_clock_count  = one_cnt_q;
  assign zero_flag        = zero_flag_q;
  assign one_flag         = one_flag_q;

`ifdef PID_ERR_FLAG_EN
  logic sat_q, sat_d;
  logic err_flag_q, err_flag_d;

  // sat remembers that a rise arrived while the count was already pinned at its maximum.
  always_comb begin
    sat_d = sat_q;
    if (burst_start) begin
      sat_d = 1'b0;
    end else if ((state_q == BURST) && rise && (pulse_cnt_q == CNT_MAX)) begin
      sat_d = 1'b1;
    end
    err_flag_d = burst_done && ((cls == CLS_DROP) || sat_q);
  end

  always_ff @(posedge sclk_3mhz or negedge reset_n) begin
    if (!reset_n) begin
      sat_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      sat_q      <= sat_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign err_flag = err_flag_q;
`endif

endmodule

// File: tb/tb_pulse_interval_decode.sv
`timescale 1ns/1ps
// Randomised self-checking bench for pulse_interval_decode against a burst-level reference model.
module tb_pulse_interval_decode;

  localparam int CLK_HALF = 167;
  localparam int PULSE_HI = 340;
  localparam int PULSE_LO = 328;
  localparam int CARRIER  = PULSE_HI + PULSE_LO;
  localparam int MIN_P    = 3;
  localparam int ONE_MIN  = 8;
  localparam int CNT_MAX  = 31;

  logic       sclk_3mhz = 1'b0;
  logic       reset_n   = 1'b1;
  logic       zcd_pulse = 1'b0;
  logic [4:0] zero_clock_count;
  logic [4:0] one_clock_count;
  logic       zero_flag;
  logic       one_flag;
`ifdef PID_ERR_FLAG_EN
  logic       err_flag;
`endif

  pulse_interval_decode dut (
    .sclk_3mhz       (sclk_3mhz),
    .reset_n         (reset_n),
    .zcd_pulse       (zcd_pulse),
    .zero_clock_count(zero_clock_count),
    .one_clock_count (one_clock_count),
    .zero_flag       (zero_flag),
    .one_flag        (one_flag)
`ifdef PID_ERR_FLAG_EN
    ,
    .err_flag        (err_flag)
`endif
  );

  always #CLK_HALF sclk_3mhz = ~sclk_3mhz;

  int checks   = 0;
  int failures = 0;

  // Monitor: strobe totals and protocol violations, sampled on the falling edge.
  int   zero_seen   = 0;
  int   one_seen    = 0;
  int   err_seen    = 0;
  int   both_viol   = 0;
  int   consec_viol = 0;
  logic prev_flag   = 1'b0;

  always @(negedge sclk_3mhz) begin
    if (!reset_n) begin
      prev_flag = 1'b0;
    end else begin
      if (zero_flag) zero_seen++;
      if (one_flag) one_seen++;
`ifdef PID_ERR_FLAG_EN
      if (err_flag) err_seen++;
`endif
      if (zero_flag && one_flag) both_viol++;
      if (prev_flag && (zero_flag || one_flag)) consec_viol++;
      prev_flag = zero_flag | one_flag;
    end
  end

  // Reference model state: the counts the outputs should hold.
  int exp_zero = 0;
  int exp_one  = 0;

  task automatic send_pulses(input int n);
    @(posedge sclk_3mhz);
    #100;
    repeat (n) begin
      zcd_pulse = 1'b1;
      #PULSE_HI;
      zcd_pulse = 1'b0;
      #PULSE_LO;
    end
  endtask

  task automatic wait_silence();
    #(4 * CARRIER);
    repeat (4) @(posedge sclk_3mhz);
    #50;
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({zero_clock_count, one_clock_count, zero_flag, one_flag} !== 12'd0) begin
      failures++;
      $display("FAIL %s outputs got zc=%0d oc=%0d zf=%0b of=%0b exp all 0", name,
               zero_clock_count, one_clock_count, zero_flag, one_flag);
    end
  endtask

  task automatic check_burst(input string name, input int n, input int z0, input int o0,
                             input int e0);
    int ez;
    int eo;
    ez = (n >= MIN_P && n < ONE_MIN) ? 1 : 0;
    eo = (n >= ONE_MIN) ? 1 : 0;
    if (ez == 1) exp_zero = n;
    if (eo == 1) exp_one = (n > CNT_MAX) ? CNT_MAX : n;

    checks++;
    if ((zero_seen - z0) !== ez) begin
      failures++;
      $display("FAIL %s n=%0d zero_flag strobes got=%0d exp=%0d", name, n, zero_seen - z0, ez);
    end
    checks++;
    if ((one_seen - o0) !== eo) begin
      failures++;
      $display("FAIL %s n=%0d one_flag strobes got=%0d exp=%0d", name, n, one_seen - o0, eo);
    end
    checks++;
    if (int'(zero_clock_count) !== exp_zero) begin
      failures++;
      $display("FAIL %s n=%0d zero_clock_count got=%0d exp=%0d", name, n, zero_clock_count, exp_zero);
    end
    checks++;
    if (int'(one_clock_count) !== exp_one) begin
      failures++;
      $display("FAIL %s n=%0d one_clock_count got=%0d exp=%0d", name, n, one_clock_count, exp_one);
    end
`ifdef PID_ERR_FLAG_EN
    begin
      int ee;
      ee = (n < MIN_P || n > CNT_MAX) ? 1 : 0;
      checks++;
      if ((err_seen - e0) !== ee) begin
        failures++;
        $display("FAIL %s n=%0d err_flag strobes got=%0d exp=%0d", name, n, err_seen - e0, ee);
      end
    end
`else
    if (e0 < 0) $display("note: negative err snapshot %0d", e0);
`endif
  endtask

  task automatic run_burst(input string name, input int n);
    int z0;
    int o0;
    int e0;
    z0 = zero_seen;
    o0 = one_seen;
    e0 = err_seen;
    send_pulses(n);
    wait_silence();
    check_burst(name, n, z0, o0, e0);
  endtask

  task automatic test_reset();
    #5 reset_n = 1'b0;
    #300;
    check_outputs_zero("reset_held");
    #366;
    @(negedge sclk_3mhz);
    reset_n = 1'b1;
    repeat (10) @(negedge sclk_3mhz);
    check_outputs_zero("reset_released_idle");
    checks++;
    if ((zero_seen + one_seen) !== 0) begin
      failures++;
      $display("FAIL reset_no_strobe got=%0d exp=0", zero_seen + one_seen);
    end
  endtask

  task automatic test_zero_symbol();
    run_burst("zero_5", 5);
  endtask

  task automatic test_one_symbol();
    run_burst("one_10", 10);
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 10; i++) run_burst("alternate", (i % 2 == 0) ? 5 : 10);
  endtask

  task automatic test_reject();
    run_burst("reject_2", 2);
    run_burst("edge_min_3", MIN_P);
    run_burst("edge_below_one_7", ONE_MIN - 1);
    run_burst("edge_one_8", ONE_MIN);
  endtask

  task automatic test_held_high();
    int z0;
    int o0;
    int e0;
    z0 = zero_seen;
    o0 = one_seen;
    e0 = err_seen;
    @(posedge sclk_3mhz);
    #100 zcd_pulse = 1'b1;
    repeat (12) @(posedge sclk_3mhz);
    #100 zcd_pulse = 1'b0;
    wait_silence();
    check_burst("held_high", 1, z0, o0, e0);
  endtask

  task automatic test_saturate();
    run_burst("saturate_40", 40);
    run_burst("exact_31", 31);
  endtask

  task automatic test_reset_mid_burst();
    int z0;
    int o0;
    z0 = zero_seen;
    o0 = one_seen;
    send_pulses(4);
    #100 reset_n = 1'b0;
    #50;
    check_outputs_zero("mid_burst_reset_held");
    #616;
    @(negedge sclk_3mhz);
    reset_n  = 1'b1;
    exp_zero = 0;
    exp_one  = 0;
    wait_silence();
    check_outputs_zero("mid_burst_after_release");
    checks++;
    if ((zero_seen - z0) + (one_seen - o0) !== 0) begin
      failures++;
      $display("FAIL mid_burst_no_strobe got=%0d exp=0", (zero_seen - z0) + (one_seen - o0));
    end
    run_burst("after_mid_reset", 5);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) run_burst("random", int'($urandom_range(1, 40)));
  endtask

  task automatic test_protocol();
    checks++;
    if (both_viol !== 0) begin
      failures++;
      $display("FAIL flags_exclusive violations got=%0d exp=0", both_viol);
    end
    checks++;
    if (consec_viol !== 0) begin
      failures++;
      $display("FAIL flags_not_consecutive violations got=%0d exp=0", consec_viol);
    end
  endtask

  initial begin
    test_reset();
    test_zero_symbol();
    test_one_symbol();
    test_alternate();
    test_reject();
    test_held_high();
    test_saturate();
    test_reset_mid_burst();
    test_random();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
